// File: rtl/stopwatch_display_mux.sv
// Scans eight stopwatch BCD digits onto a common-anode 8-digit 7-segment display.
// Define DISP_LZ_BLANK_EN to blank leading zeros in the hours field.
module stopwatch_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_hr_1,
  input  logic [3:0] i_hr_0,
  input  logic [3:0] i_min_1,
  input  logic [3:0] i_min_0,
  input  logic [3:0] i_sec_1,
  input  logic [3:0] i_sec_0,
  input  logic [3:0] i_cent_1,
  input  logic [3:0] i_cent_0,
  output logic [7:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CBLK = CW'(BLANK_CYC);

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0][3:0] r_snap;

  logic [7:0][3:0] w_in;
  logic            w_wrap;
  logic            w_frame;
  logic            w_blank;
  logic [3:0]      w_dig;
  logic [7:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;

  assign w_in    = {i_hr_1, i_hr_0, i_min_1, i_min_0,
                    i_sec_1, i_sec_0, i_cent_1, i_cent_0};
  assign w_wrap  = (r_cnt == CMAX);
  assign w_frame = (r_cnt == '0) && (r_idx == 3'd0);
  assign w_blank = (r_cnt < CBLK);
  assign w_dig   = r_snap[r_idx];

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Latch a whole frame at once so a digit rollover never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (w_frame) begin
      r_snap <= w_in;
    end
  end

  always_comb begin
    w_an  = 8'hFF;
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    if (!w_blank) begin
      w_an  = ~(8'd1 << r_idx);
      w_seg = dec(w_dig);
      w_dp  = ~((r_idx != 3'd0) && !r_idx[0]);
`ifdef DISP_LZ_BLANK_EN
      if (r_idx == 3'd7 && r_snap[7] == 4'd0) begin
        w_seg = 7'h7F;
      end
      if (r_idx == 3'd6 && r_snap[7] == 4'd0
          && r_snap[6] == 4'd0) begin
        w_seg = 7'h7F;
        w_dp  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_an  <= 8'hFF;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= w_an;
      o_seg <= w_seg;
      o_dp  <= w_dp;
    end
  end

endmodule

// File: doc/stopwatch_display_mux.md
Name: stopwatch_display_mux

Overview:
- Downstream of the stopwatch counter stage.
- Consumes the eight BCD digits (hours, minutes, seconds, centiseconds) and time-multiplexes them onto an 8-digit common-anode 7-segment display.
- Internal blocks: refresh prescaler, digit-scan counter, per-frame snapshot register (prevents tearing), registered BCD-to-segment decode with anti-ghosting blanking.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYC, 2, leading cycles of each slot with all anodes off; legal range 1 ≤ BLANK_CYC < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_hr_1, i_hr_0, i_min_1, i_min_0, i_sec_1, i_sec_0, i_cent_1, i_cent_0  in  4 each  BCD digits from counter stage
- o_an  out  8  digit anodes, active-low; bit0 = rightmost digit
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  out  1  decimal point, active-low

Behaviour:
- Clocking and reset: one clock (clk); rst_n asynchronous, active-low.
- Reset state: cnt=0, idx=0, snapshot=all zero, o_an=8'hFF, o_seg=7'h7F, o_dp=1.
- Reset mid-scan: all state returns to reset values immediately. Scan restarts at idx 0 on the first edge after release.
- Prescaler cnt: counts 0..REFRESH_DIV-1. At cnt==REFRESH_DIV-1, cnt wraps to 0 and idx increments, 7→0 wrap.
- Snapshot: loads all eight inputs on any edge whose pre-edge state is cnt==0 && idx==0 (frame start, including the first cycle after reset). Otherwise holds. Input changes mid-frame are not visible until the next frame.
- Slot mapping (idx → digit → anode): 0→cent_0→an[0], 1→cent_1→an[1], 2→sec_0→an[2], 3→sec_1→an[3], 4→min_0→an[4], 5→min_1→an[5], 6→hr_0→an[6], 7→hr_1→an[7].
- Outputs are registered with 1-cycle latency: the value after edge k+1 is a function of cnt, idx and snapshot after edge k.
  - Blank phase (cnt < BLANK_CYC): o_an=8'hFF, o_seg=7'h7F, o_dp=1.
  - Otherwise: o_an = ~(1<<idx); o_seg = decode(snapshot[idx]); o_dp = 0 when idx ∈ {2,4,6}, else 1. This renders HH.MM.SS.CC.
- Decode table (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10–15 show a dash = 3F (g only).
- Full frame = 8*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-BLANK_CYC cycles per frame.

Optional Feature:
- Macro: DISP_LZ_BLANK_EN.
- Defined:
  - Slot 7 shows o_seg=7F when snapshot hr_1==0.
  - Slot 6 shows o_seg=7F and o_dp=1 when snapshot hr_1==0 and hr_0==0.
  - Anode timing is unchanged; the digit is dark but still scanned.
  - Other digits are never blanked.
- Undefined: all digits are always shown, including leading zeros.

Test Plan (REFRESH_DIV=4, BLANK_CYC=1):
- Reset: assert rst_n=0 mid-slot (idx=3, cnt=2) → o_an=FF, o_seg=7F, o_dp=1 immediately. After release, first non-blank output is o_an=FE at cycle 2, showing the snapshot's cent_0.
- Scan: inputs hr=12, min=34, sec=56, cent=78 held constant; capture one frame → o_an=FE seg=00 (8), FD seg=78 (7), FB seg=02 dp=0 (6), F7 seg=12 (5), EF seg=19 dp=0 (4), DF seg=30 (3), BF seg=24 dp=0 (2), 7F seg=79 (1). Each is lit 3 cycles preceded by 1 blank cycle.
- Wrap: run 2 frames → idx 7→0 transition goes blank then o_an=FE. Period is exactly 32 cycles.
- Tearing: change i_cent_0 from 8 to 3 while idx=4 → slot 0 still shows 00 for the rest of the frame. Next frame shows 30.
- Invalid code: i_min_1=4'hC → slot 5 shows o_seg=3F. No other slot is affected.
- Leading-zero blanking (DISP_LZ_BLANK_EN defined): hr=00, min=05 → slots 6 and 7 show seg=7F with o_dp=1 on slot 6. With hr=03, slot 6 shows 30 with dp=0 and slot 7 shows 7F. With the macro undefined, hr=00 shows 40 on both slots.
